// File: rtl/big_ula_seq_if.sv
`default_nettype none
// ============================================================================
// big_ula_seq_if : control-unit <-> arithmetic unit handshake and operand bus
// Rev 1.0
// ============================================================================
interface big_ula_seq_if #(
  parameter int W = 29
);
  logic         start;
  logic         op;
  logic         sign_a;
  logic         sign_b;
  logic [W-1:0] fract_a;
  logic [W-1:0] fract_b;
  logic [W-1:0] result;
  logic         sign_out;
  logic         busy;
  logic         done;

  modport master (
    output start, op, sign_a, sign_b, fract_a, fract_b,
    input  result, sign_out, busy, done
  );

  modport slave (
    input  start, op, sign_a, sign_b, fract_a, fract_b,
    output result, sign_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/big_ula_seq.sv
`default_nettype none
// ============================================================================
// big_ula_seq : sign-magnitude add (1 cycle) / shift-add multiply (27 cycles)
// Rev 1.0
// ============================================================================
module big_ula_seq #(
  parameter int W        = 29,
  parameter int MUL_BITS = 27
) (
  input  wire logic     clk,
  input  wire logic     reset,
  big_ula_seq_if.slave  bus
);
  localparam int ACC_W = 2 * MUL_BITS;
  localparam int CW    = $clog2(MUL_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           op_q, op_d;
  logic           sign_a_q, sign_a_d;
  logic           sign_b_q, sign_b_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;
  logic           sign_out_q, sign_out_d;

  logic [ACC_W-1:0] partial;
  logic [ACC_W-1:0] product;
  logic [W-1:0]     sum;
  logic             a_gt_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      sign_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      sign_out_q <= sign_out_d;
    end
  end

  // Only the hidden one and mantissa bits [26:0] take part in the product.
  assign partial = b_q[cnt_q]
                 ? ({{MUL_BITS{1'b0}}, a_q[MUL_BITS-1:0]} << cnt_q)
                 : '0;
  assign product = acc_q + partial;
  assign sum     = a_q + b_q;
  assign a_gt_b  = (a_q > b_q);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    sign_out_d = sign_out_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          sign_a_d = bus.sign_a;
          sign_b_d = bus.sign_b;
          a_d      = bus.fract_a;
          b_d      = bus.fract_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = bus.op ? MUL : ADD;
        end
      end

      ADD: begin
        if (sign_a_q == sign_b_q) begin
          result_d   = sum;
          sign_out_d = sign_a_q;
        end else if (a_gt_b) begin
          result_d   = a_q - b_q;
          sign_out_d = sign_a_q;
        end else if (b_q > a_q) begin
          result_d   = b_q - a_q;
          sign_out_d = sign_b_q;
        end else begin
          result_d   = '0;
          sign_out_d = 1'b0;
        end
        state_d = DONE;
      end

      MUL: begin
        acc_d = product;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MUL_BITS - 1)) begin
          // Top W-1 product bits become the fraction; the rest fold into sticky.
          result_d    = {1'b0, product[ACC_W-1 -: W-1]};
          result_d[0] = product[ACC_W-W+1] | (|product[ACC_W-W:0]);
          sign_out_d  = sign_a_q ^ sign_b_q;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (!bus.start) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.result   = result_q;
  assign bus.sign_out = sign_out_q;
  assign bus.busy     = (state_q == ADD) || (state_q == MUL);
  assign bus.done     = (state_q == DONE);

  logic unused_op;
  assign unused_op = op_q;
endmodule
`default_nettype wire

// File: tb/tb_big_ula_seq.sv
`default_nettype none
// ============================================================================
// tb_big_ula_seq : scoreboard bench for big_ula_seq add/multiply handshake
// Rev 1.0
// ============================================================================
module tb_big_ula_seq;
  logic clk;
  logic reset;

  big_ula_seq_if #(.W(29)) bus ();

  big_ula_seq #(.W(29), .MUL_BITS(27)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [29:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] model(input logic op, input logic sa, input logic sb,
                                        input logic [28:0] fa, input logic [28:0] fb);
    logic [53:0] p;
    logic [28:0] r;
    logic        s;
    if (op) begin
      p = 54'(fa[26:0]) * 54'(fb[26:0]);
      r = {1'b0, p[53:26]};
      r[0] = r[0] | (|p[25:0]);
      s = sa ^ sb;
    end else if (sa == sb) begin
      r = fa + fb;
      s = sa;
    end else if (fa > fb) begin
      r = fa - fb;
      s = sa;
    end else if (fb > fa) begin
      r = fb - fa;
      s = sb;
    end else begin
      r = '0;
      s = 1'b0;
    end
    return {s, r};
  endfunction

  // Drives a request, waits for the capture edge, then scrambles the inputs.
  task automatic launch(input logic op, input logic sa, input logic sb,
                        input logic [28:0] fa, input logic [28:0] fb);
    bus.op      = op;
    bus.sign_a  = sa;
    bus.sign_b  = sb;
    bus.fract_a = fa;
    bus.fract_b = fb;
    bus.start   = 1'b1;
    exp_q.push_back(model(op, sa, sb, fa, fb));
    @(posedge clk); #1;
    chk("busy_after_capture", 64'(bus.busy), 64'd1);
    bus.op      = ~op;
    bus.sign_a  = ~sa;
    bus.sign_b  = ~sb;
    bus.fract_a = 29'($urandom);
    bus.fract_b = 29'($urandom);
  endtask

  task automatic finish_op(input string tag, input int exp_cyc);
    int n;
    logic [29:0] e;
    n = 0;
    while (!bus.done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_cyc));
    chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_result"}, 64'(bus.result), 64'(e[28:0]));
      chk({tag, "_sign"}, 64'(bus.sign_out), 64'(e[29]));
    end
  endtask

  task automatic release_start(input string tag);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_clear"}, 64'(bus.done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 1'b0;
    bus.sign_a  = 1'b0;
    bus.sign_b  = 1'b0;
    bus.fract_a = '0;
    bus.fract_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_sign", 64'(bus.sign_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    launch(1'b0, 1'b0, 1'b0, 29'h0400_0000, 29'h0400_0000);
    finish_op("add_1p1", 1);
    release_start("add_1p1");

    launch(1'b0, 1'b0, 1'b1, 29'h0400_0000, 29'h0600_0000);
    finish_op("sub", 1);
    release_start("sub");

    launch(1'b0, 1'b1, 1'b0, 29'h0555_0000, 29'h0555_0000);
    finish_op("sub_equal", 1);
    release_start("sub_equal");

    launch(1'b0, 1'b1, 1'b1, 29'h1F00_0000, 29'h1200_0000);
    finish_op("add_wrap", 1);
    release_start("add_wrap");

    launch(1'b1, 1'b1, 1'b0, 29'h0600_0000, 29'h0600_0000);
    finish_op("mul_1p5", 27);
    release_start("mul_1p5");

    launch(1'b1, 1'b0, 1'b0, 29'h0400_0001, 29'h0400_0001);
    finish_op("mul_sticky", 27);
    release_start("mul_sticky");

    launch(1'b1, 1'b1, 1'b0, 29'h0000_0000, 29'h1FFF_FFFF);
    finish_op("mul_zero", 27);
    release_start("mul_zero");

    // Hold start through DONE: no relaunch.
    launch(1'b1, 1'b0, 1'b1, 29'h07FF_FFFF, 29'h1C00_0001);
    finish_op("hold", 27);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_done", 64'(bus.done), 64'd1);
      chk("hold_busy", 64'(bus.busy), 64'd0);
    end
    release_start("hold");

    // Start drops mid-multiply: done pulses once, no relaunch.
    launch(1'b1, 1'b0, 1'b0, 29'h0512_3456, 29'h06AB_CDEF);
    bus.start = 1'b0;
    finish_op("drop", 27);
    @(posedge clk); #1;
    chk("drop_pulse_end", 64'(bus.done), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("drop_stay_idle", 64'(bus.busy), 64'd0);
    end

    // Asynchronous reset at multiply iteration 10.
    launch(1'b1, 1'b1, 1'b0, 29'h0600_0000, 29'h0600_0000);
    void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_result", 64'(bus.result), 64'd0);
    chk("arst_sign", 64'(bus.sign_out), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    bus.op      = 1'b1;
    bus.sign_a  = 1'b0;
    bus.sign_b  = 1'b1;
    bus.fract_a = 29'h0700_0000;
    bus.fract_b = 29'h0480_0000;
    @(negedge clk) reset = 1'b0;
    launch(1'b1, 1'b0, 1'b1, 29'h0700_0000, 29'h0480_0000);
    finish_op("post_rst", 27);
    release_start("post_rst");

    for (int i = 0; i < 8; i++) begin
      logic rop;
      rop = 1'($urandom);
      launch(rop, 1'($urandom), 1'($urandom), 29'($urandom), 29'($urandom));
      finish_op("rand", rop ? 27 : 1);
      release_start("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/big_ula_seq.md
# big_ula_seq

Sequential arithmetic responder for the floating-point datapath: on the control unit's start request, it adds two sign-magnitude fractions or multiplies them. Add takes one cycle; multiply runs a 27-iteration shift-add loop. It reports completion on `done` and holds the 29-bit result for the normalization loop. It sits between the operand-alignment shifter and the normalizer/rounder, and answers the control unit's `ULA_START`/`done_ULA` handshake.

## Interface
- `W`, 29: fraction width. Layout: [28:27] overflow, [26] hidden one, [25:3] mantissa, [2:0] guard/round/sticky.
- `MUL_BITS`, 27: multiplier iterations (bits [26:0]).
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  level request from the control unit (`ULA_START`); may stay high indefinitely.
- `op`  in  1  0 = add, 1 = multiply; sampled only with operands.
- `sign_a`, `sign_b`  in  1  operand signs (1 = negative).
- `fract_a`, `fract_b`  in  29  aligned operand magnitudes.
- `result`  out  29  magnitude of the result.
- `sign_out`  out  1  sign of the result.
- `busy`  out  1  high while in ADD or MUL.
- `done`  out  1  high in DONE; drives the control unit's `done_ULA`.

## Operation
- States: IDLE, ADD, MUL, DONE. Reset → IDLE; `result`=0, `sign_out`=0, `busy`=0, `done`=0, iteration counter=0, accumulator=0.
- IDLE: if `start`=1, capture `op`, signs and fractions into internal registers. Go to ADD if `op`=0, MUL if `op`=1. Inputs changing after capture have no effect.
- ADD, one cycle, then → DONE:
  - Equal signs: `result` = a+b mod 2^29; `sign_out` = `sign_a`.
  - Different signs: `result` = larger − smaller; `sign_out` = sign of the larger.
  - Equal magnitudes with different signs: `result`=0, `sign_out`=0.
- MUL, 27 cycles:
  - Iteration i (i = 0..26): if b[i]=1, add a[26:0] << i into the 54-bit accumulator. Bits [28:27] of both operands are ignored.
  - On the last iteration, write `result`[28]=0 and `result`[27:0] = P[53:26].
  - Then set `result`[0] to its own value OR'd with the OR of P[25:0] (sticky), where P is the final product.
  - `sign_out` = `sign_a` XOR `sign_b`. Go to DONE.
- DONE: `done`=1; `result` and `sign_out` held. If `start`=0, the next edge clears `done` and returns to IDLE. If `start` stays 1, remain in DONE; no relaunch occurs (four-phase handshake).
- `result` and `sign_out` keep their last value until the next operation writes them.

## Timing
- Count from edge k, the first edge at which IDLE samples `start`=1. `busy` is high after edge k.
- Add: result and `done` are valid after edge k+1; `busy` drops at the same edge.
- Multiply: the counter advances on edges k+1..k+27. Result and `done` are valid after edge k+27.
- `start` dropping mid-operation does not abort. The operation completes, `done` is high for exactly one cycle, then the block returns to IDLE.
- A new request is accepted no earlier than the edge after the return to IDLE. Back-to-back handshakes therefore need `start` low for at least one sampled edge while in DONE.
- Zero operand in multiply yields `result`=0, with `sign_out` = XOR of the signs.
- `reset` asserted mid-operation clears everything asynchronously. After release, the block sits in IDLE; if `start` is still high, a new capture occurs at the first post-reset edge.

## Test plan
- Add 1.0 + 1.0 (29'h0400_0000 ×2, signs 0, `op`=0) → `result`=29'h0800_0000, `sign_out`=0; `done` is high after edge k+1.
- Subtract: a=29'h0400_0000 (sign 0), b=29'h0600_0000 (sign 1) → `result`=29'h0200_0000, `sign_out`=1. Repeat with equal magnitudes → `result`=0, `sign_out`=0.
- Multiply 1.5×1.5 (29'h0600_0000 ×2, `sign_a`=1, `sign_b`=0) → `result`=29'h0900_0000, `sign_out`=1; `done` rises after exactly 27 cycles in MUL (edge k+27).
- Sticky: 29'h0400_0001 × 29'h0400_0001 → `result`=29'h0400_0003.
- Handshake: hold `start` high through DONE → `done` stays 1 and there is no relaunch. Drop `start` → IDLE at the next edge. Drop `start` during MUL → `done` pulses for one cycle.
- Reset at MUL iteration 10 → all outputs 0 immediately; with `start` high after release, a fresh multiply completes with correct values.
